serial_demux_1by8: RTL and testbench

//   Registered 1-to-8 demultiplexer / deserializer: the receive end of an 8:1 select-mux serial link.

---
 rtl/serial_demux_1by8.sv | 76 +++++++
 tb/tb_serial_demux_1by8.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_demux_1by8.sv
// Receive end of an 8:1 select-mux serial link: steers each accepted bit into the
// slot picked by a 3-bit counter and presents the finished word on a valid/ready port.
module serial_demux_1by8 #(
  parameter int N_OUT = 8,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             sof,
  output logic [N_OUT-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [SEL_W-1:0] slot,
  output logic             frame_err
);

  localparam logic [SEL_W-1:0] LAST_SLOT = SEL_W'(N_OUT - 1);

  logic [SEL_W-1:0] r_slot;
  logic [N_OUT-1:0] r_asm;
  logic [N_OUT-1:0] r_dout;
  logic             r_dout_valid;
  logic             r_frame_err;

  logic             w_accept;
  logic [SEL_W-1:0] w_ts;
  logic             w_last;
  logic [N_OUT-1:0] w_asm_next;

  // Stall only the final bit of a frame, and only when the held word cannot leave.
  assign din_ready = !((r_slot == LAST_SLOT) && r_dout_valid && !dout_ready);
  assign w_accept  = din_valid && din_ready;
  assign w_ts      = sof ? '0 : r_slot;
  assign w_last    = (w_ts == LAST_SLOT);

  always_comb begin
    w_asm_next       = r_asm;
    w_asm_next[w_ts] = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_slot       <= '0;
      r_asm        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_frame_err <= w_accept && sof && (r_slot != '0);
      if (w_accept) begin
        r_asm <= w_asm_next;
        if (w_last) begin
          r_dout <= w_asm_next;
          r_slot <= '0;
        end else begin
          r_slot <= w_ts + SEL_W'(1);
        end
      end
      // A completing frame wins over the consumer draining the held word.
      if (w_accept && w_last) begin
        r_dout_valid <= 1'b1;
      end else if (dout_ready) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign slot       = r_slot;
  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign frame_err  = r_frame_err;

endmodule

// File: tb/tb_serial_demux_1by8.sv
// Bench for serial_demux_1by8: directed scenarios plus randomized frames, checked
// against a cycle model of the slot/handshake rules and a word scoreboard.
module tb_serial_demux_1by8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       din_ready;
  logic       sof = 1'b0;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready = 1'b1;
  logic [2:0] slot;
  logic       frame_err;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 1'b0;
  bit rnd_ready = 1'b0;

  // reference model state
  int       m_slot = 0;
  bit [7:0] m_bits = '0;
  bit [7:0] m_dout = '0;
  bit       m_vld = 1'b0;
  bit       m_err = 1'b0;
  logic [7:0] exp_q[$];

  serial_demux_1by8 #(.N_OUT(8), .SEL_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .sof(sof), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .slot(slot), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_ready();
    return !(m_slot == 7 && m_vld && !dout_ready);
  endfunction

  always @(negedge rst_n) begin
    m_slot = 0; m_bits = '0; m_dout = '0; m_vld = 1'b0; m_err = 1'b0;
    exp_q.delete();
  end

  always @(posedge clk) begin
    if (rst_n) begin
      bit acc, done;
      int tgt;
      acc  = din_valid && m_ready();
      done = 1'b0;
      m_err = 1'b0;
      if (acc) begin
        tgt = sof ? 0 : m_slot;
        m_err = sof && (m_slot != 0);
        m_bits[tgt] = din;
        if (tgt == 7) begin
          done = 1'b1;
          m_slot = 0;
        end else begin
          m_slot = tgt + 1;
        end
      end
      if (done) begin
        m_dout = m_bits;
        m_vld = 1'b1;
      end else if (dout_ready) begin
        m_vld = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("slot", slot, m_slot);
      chk("din_ready", din_ready, m_ready());
      chk("dout_valid", dout_valid, m_vld);
      chk("dout", dout, m_dout);
      chk("frame_err", frame_err, m_err);
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) chk("sb_unexpected_word", 1, 0);
        else chk("sb_word", dout, exp_q.pop_front());
      end
    end
  end

  always @(posedge clk) begin
    if (rnd_ready) begin
      #1 dout_ready = 1'($urandom_range(0, 1));
    end
  end

  // Enters and leaves at one time unit after a rising edge.
  task automatic send_bit(input logic b, input logic s, input int gap);
    int n;
    repeat (gap) begin
      @(posedge clk); #1;
    end
    din = b; sof = s; din_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!din_ready && n < 200) begin
      n++;
      @(negedge clk);
    end
    if (!din_ready) chk("ready_timeout", 0, 1);
    @(posedge clk); #1;
    din_valid = 1'b0; sof = 1'b0; din = 1'($urandom_range(0, 1));
  endtask

  task automatic send_bits(input logic [7:0] w, input int lo, input int hi, input int gmax);
    for (int k = lo; k <= hi; k++)
      send_bit(w[k], k == 0, gmax > 0 ? int'($urandom_range(0, gmax)) : 0);
    if (hi == 7) exp_q.push_back(w);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_dout", dout, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_slot", slot, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_ready", din_ready, 1);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    // 1: basic frame
    dout_ready = 1'b1;
    send_bits(8'h4D, 0, 7, 0);
    @(negedge clk);
    chk("t1_dout", dout, 8'h4D);
    chk("t1_valid", dout_valid, 1);
    @(negedge clk);
    chk("t1_valid_drop", dout_valid, 0);
    @(posedge clk); #1;

    // 2: back-pressure
    dout_ready = 1'b0;
    send_bits(8'hA5, 0, 7, 0);
    fork
      send_bits(8'h3C, 0, 7, 0);
      begin
        int n = 0;
        while (slot != 3'd7 && n < 100) begin
          @(negedge clk); n++;
        end
        repeat (3) begin
          @(negedge clk);
          chk("t2_hold", dout, 8'hA5);
          chk("t2_stall", din_ready, 0);
        end
        @(posedge clk); #1 dout_ready = 1'b1;
      end
    join
    @(negedge clk);
    chk("t2_next", dout, 8'h3C);
    chk("t2_valid", dout_valid, 1);
    @(posedge clk); #1;

    // 3: completion while a word is taken
    dout_ready = 1'b0;
    send_bits(8'h11, 0, 7, 0);
    send_bits(8'h96, 0, 6, 0);
    dout_ready = 1'b1;
    send_bits(8'h96, 7, 7, 0);
    @(negedge clk);
    chk("t3_valid", dout_valid, 1);
    chk("t3_dout", dout, 8'h96);
    @(posedge clk); #1;

    // 4: frame abort
    send_bits(8'hFF, 0, 4, 0);
    @(negedge clk);
    chk("t4_slot5", slot, 5);
    @(posedge clk); #1;
    send_bits(8'h5A, 0, 0, 0);
    @(negedge clk);
    chk("t4_err", frame_err, 1);
    chk("t4_slot1", slot, 1);
    @(negedge clk);
    chk("t4_err_clear", frame_err, 0);
    @(posedge clk); #1;
    send_bits(8'h5A, 1, 7, 0);
    @(negedge clk);
    chk("t4_dout", dout, 8'h5A);
    @(posedge clk); #1;

    // 5: reset mid-frame with a held word
    dout_ready = 1'b0;
    send_bits(8'hC3, 0, 7, 0);
    send_bits(8'h77, 0, 3, 0);
    @(negedge clk);
    chk("t5_slot4", slot, 4);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_dout", dout, 0);
    chk("t5_valid", dout_valid, 0);
    chk("t5_slot", slot, 0);
    chk("t5_ready", din_ready, 1);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    dout_ready = 1'b1;
    send_bits(8'h77, 0, 7, 0);
    @(negedge clk);
    chk("t5_after", dout, 8'h77);
    @(posedge clk); #1;

    // 6: gaps between bits
    send_bits(8'hF0, 0, 7, 3);
    @(negedge clk);
    chk("t6_dout", dout, 8'hF0);
    @(posedge clk); #1;

    // random frames, aborts and consumer stalls
    rnd_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      logic [7:0] w;
      w = 8'($urandom);
      if ($urandom_range(0, 7) == 0) send_bits(w, 0, int'($urandom_range(0, 6)), 2);
      else send_bits(w, 0, 7, 2);
    end
    rnd_ready = 1'b0;
    @(posedge clk); #2 dout_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("sb_drain", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
